line_read_extract: RTL

- Read-side counterpart of the 128-bit line merge path: holds one 128-bit line fetched from physical memory.
- Serves 16-bit CPU reads out of that line with byte-lane selection.
- Sits between the LC-3b datapath read port (mem_*) and the line-wide memory port (pmem_*).
- One-line read buffer with fill FSM, invalidate snoop and hit/miss counters.

---
 rtl/lc3b_types.sv | 9 +
 rtl/line_read_extract_word_select.sv | 13 +
 rtl/line_read_extract.sv | 90 +++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word, mask, line and line-read FSM types
package lc3b_types;
    typedef logic [15:0] lc3b_word;
    typedef logic [1:0] lc3b_mem_wmask;
    typedef logic [127:0] lc3b_line;
    typedef logic [11:0] lc3b_line_tag;
    typedef logic [2:0] lc3b_line_offset;
    typedef enum logic [1:0] {LR_IDLE, LR_FETCH, LR_RESPOND} line_rd_state_t;
endpackage

// File: rtl/line_read_extract_word_select.sv
// line_word_select: picks one 16-bit word from a line and zeroes disabled byte lanes
module line_word_select
    import lc3b_types::*;
(
    input  lc3b_line        line,
    input  lc3b_line_offset offset,
    input  lc3b_mem_wmask   be,
    output lc3b_word        word
);
    lc3b_word w;
    assign w = line[{offset, 4'h0} +: 16];
    assign word = {be[1] ? w[15:8] : 8'h00, be[0] ? w[7:0] : 8'h00};
endmodule

// File: rtl/line_read_extract.sv
// line_read_extract: one-line read buffer serving masked 16-bit CPU reads from a 128-bit memory line
module line_read_extract
    import lc3b_types::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 mem_read,
    input  logic [15:0]          mem_address,
    input  logic [1:0]           mem_byte_enable,
    output logic [15:0]          mem_rdata,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic [15:0]          pmem_address,
    input  logic [127:0]         pmem_rdata,
    input  logic                 pmem_resp,
    input  logic                 inv_valid,
    input  logic [15:0]          inv_address,
    input  logic                 cnt_clear,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);
    line_rd_state_t state;
    lc3b_line line;
    lc3b_line_tag tag;
    lc3b_word hit_word, fill_word;
    logic valid, fill_inv, inv_tag, inv_fill, hit, inc_hit, inc_miss, unused;
    assign inv_tag = inv_valid && inv_address[15:4] == tag;
    assign inv_fill = inv_valid && inv_address[15:4] == mem_address[15:4];
    assign hit = valid && tag == mem_address[15:4] && !inv_tag;
    assign inc_hit = state == LR_IDLE && mem_read && hit;
    assign inc_miss = state == LR_IDLE && mem_read && !hit;
    assign mem_resp = state == LR_RESPOND;
    assign pmem_read = state == LR_FETCH;
    assign pmem_address = {mem_address[15:4], 4'h0};
    assign unused = ^{mem_address[0], inv_address[3:0]};
    line_word_select u_hit_sel (
        .line  (line),
        .offset(mem_address[3:1]),
        .be    (mem_byte_enable),
        .word  (hit_word)
    );
    line_word_select u_fill_sel (
        .line  (pmem_rdata),
        .offset(mem_address[3:1]),
        .be    (mem_byte_enable),
        .word  (fill_word)
    );
    // fill_inv remembers an invalidate of the line being fetched so the fill lands invalid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= LR_IDLE;
            line <= '0;
            tag <= '0;
            valid <= 1'b0;
            fill_inv <= 1'b0;
            mem_rdata <= '0;
        end else begin
            case (state)
                LR_IDLE: if (mem_read) begin
                    state <= hit ? LR_RESPOND : LR_FETCH;
                    fill_inv <= 1'b0;
                    if (hit) mem_rdata <= hit_word;
                end
                LR_FETCH: begin
                    if (inv_fill) fill_inv <= 1'b1;
                    if (pmem_resp) begin
                        line <= pmem_rdata;
                        tag <= mem_address[15:4];
                        mem_rdata <= fill_word;
                        state <= LR_RESPOND;
                    end
                end
                default: state <= LR_IDLE;
            endcase
            if (state == LR_FETCH && pmem_resp) valid <= !(fill_inv || inv_fill);
            else if (inv_tag) valid <= 1'b0;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count <= '0;
            miss_count <= '0;
        end else begin
            hit_count <= cnt_clear ? '0 : (inc_hit && !(&hit_count)) ? hit_count + 1'b1 : hit_count;
            miss_count <= cnt_clear ? '0 : (inc_miss && !(&miss_count)) ? miss_count + 1'b1 : miss_count;
        end
    end
endmodule
